// File: rtl/line_window_ctrl_pkg.sv
// Shared types and constants for the 3x3 line-window controller.
package line_window_ctrl_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_window_ctrl_if.sv
// Pixel-in / window-out bundle for line_window_ctrl.
interface line_window_ctrl_if #(
    parameter int PIX_W = 12
);
    // in_valid: one pixel accepted on every rising edge it is high, there is no
    // ready; in_sof is only meaningful with in_valid. win_valid, frame_done and
    // frame_err are single-cycle pulses; win/win_x/win_y hold between windows.
    logic                                  in_valid;
    logic                                  in_sof;
    logic [PIX_W-1:0]                      in_pixel;
    logic                                  win_valid;
    logic [9*PIX_W-1:0]                    win;
    logic [line_window_ctrl_pkg::COORD_W-1:0] win_x;
    logic [line_window_ctrl_pkg::COORD_W-1:0] win_y;
    logic                                  busy;
    logic                                  frame_done;
    logic                                  frame_err;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  win_valid, win, win_x, win_y, busy, frame_done, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output win_valid, win, win_x, win_y, busy, frame_done, frame_err
    );

endinterface

// File: rtl/line_window_ctrl_line_delay.sv
// Enabled delay of DEPTH samples as a circular buffer; storage has no reset.
module line_delay
    import line_window_ctrl_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1280
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;

    // Read-before-write at the same slot: the word leaving is DEPTH shifts old.
    assign dout_o = mem_q[ptr_q];

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (shift_en_i) begin
            ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

endmodule

// File: rtl/line_window_ctrl.sv
// Streams pixels through two line delays and emits 3x3 windows with centre
// coordinates; frame control via IDLE/FILL/RUN/DONE.
module line_window_ctrl
    import line_window_ctrl_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int IMG_W = 1280,
    parameter int IMG_H = 960
) (
    input  logic               clk,
    input  logic               rst_n,
    line_window_ctrl_if.slave  bus,
    output state_t             state_o
);

    localparam coord_t X_LAST = coord_t'(IMG_W - 1);
    localparam coord_t Y_LAST = coord_t'(IMG_H - 1);

    state_t state_q, state_d;
    coord_t x_q, x_d, y_q, y_d;
    coord_t cx, cy;
    logic   accept, restart, fire;
    logic   err_q;

    logic [PIX_W-1:0]   line1, line2;
    logic [PIX_W-1:0]   tap [3];
    logic [PIX_W-1:0]   col_q [3][3];
    logic [PIX_W-1:0]   col_d [3][3];
    logic [9*PIX_W-1:0] win_q, win_d;
    coord_t             win_x_q, win_y_q;
    logic               win_valid_q;

    // cx/cy are the coordinates the current pixel is taken at (0,0 on sof).
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx      = x_q;
        cy      = y_q;
        accept  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.in_valid && bus.in_sof) begin
                    accept  = 1'b1;
                    cx      = '0;
                    cy      = '0;
                    state_d = FILL;
                end
            end
            FILL, RUN: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (bus.in_sof && (x_q != '0 || y_q != '0)) begin
                        restart = 1'b1;
                        cx      = '0;
                        cy      = '0;
                        state_d = FILL;
                    end else if (state_q == FILL && x_q == X_LAST && y_q == coord_t'(1)) begin
                        state_d = RUN;
                    end else if (state_q == RUN && x_q == X_LAST && y_q == Y_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (cx == X_LAST) begin
                x_d = '0;
                y_d = (cy == Y_LAST) ? '0 : cy + coord_t'(1);
            end else begin
                x_d = cx + coord_t'(1);
                y_d = cy;
            end
        end
    end

    assign fire = accept && (cx >= coord_t'(2)) && (cy >= coord_t'(2));

    line_delay #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_delay1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (accept),
        .din_i      (bus.in_pixel),
        .dout_o     (line1)
    );

    line_delay #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_delay2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (accept),
        .din_i      (line1),
        .dout_o     (line2)
    );

    // Row 0 is the oldest line, column 0 the oldest pixel.
    assign tap[0] = line2;
    assign tap[1] = line1;
    assign tap[2] = bus.in_pixel;

    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            col_d[r][0] = col_q[r][1];
            col_d[r][1] = col_q[r][2];
            col_d[r][2] = tap[r];
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[(3*r+c)*PIX_W +: PIX_W] = col_d[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            err_q       <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    col_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            err_q       <= restart;
            win_valid_q <= fire;
            if (accept) begin
                col_q <= col_d;
            end
            if (fire) begin
                win_q   <= win_d;
                win_x_q <= cx - coord_t'(1);
                win_y_q <= cy - coord_t'(1);
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.win        = win_q;
    assign bus.win_x      = win_x_q;
    assign bus.win_y      = win_y_q;
    assign bus.busy       = (state_q == FILL) || (state_q == RUN);
    assign bus.frame_done = (state_q == DONE);
    assign bus.frame_err  = err_q;
    assign state_o        = state_q;

endmodule
